// File: rtl/alu_seq_pkg.sv
// Shared encodings for the registered ALU: opcode values and FSM state codes.
package alu_seq_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_seq_if.sv
// Command/result handshake bundle between the decode stage and the ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             ainvert;
  logic             binvert;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry;

  modport master (
    output in_valid, src1, src2, ainvert, binvert, op, out_ready,
    input  in_ready, out_valid, result, zero, overflow, carry
  );

  modport slave (
    input  in_valid, src1, src2, ainvert, binvert, op, out_ready,
    output in_ready, out_valid, result, zero, overflow, carry
  );
endinterface

// File: rtl/alu_seq_core.sv
// Combinational single-cycle datapath: AND/OR/ADD/SLT on pre-inverted operands.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_c_o,
  output logic             carry_c_o,
  output logic             ovf_c_o
);

  logic [WIDTH:0] sum;
  logic           add_ovf;

  assign sum     = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
  assign add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);

  always_comb begin
    result_c_o = '0;
    carry_c_o  = 1'b0;
    ovf_c_o    = 1'b0;
    case (op_i)
      OP_AND: result_c_o = a_i & b_i;
      OP_OR:  result_c_o = a_i | b_i;
      OP_ADD: begin
        result_c_o = sum[WIDTH-1:0];
        carry_c_o  = sum[WIDTH];
        ovf_c_o    = add_ovf;
      end
      OP_SLT: begin
        // True sign of a'-b' even when the subtraction overflows.
        result_c_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
        carry_c_o  = sum[WIDTH];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and flags.
// Define ALU_SEQ_MUL_EN to add the multi-cycle shift-add unsigned multiply (op=100).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] a_op, b_op, core_res;
  logic             core_carry, core_ovf;
  logic             accept;

  assign a_op = bus.ainvert ? ~bus.src1 : bus.src1;
  assign b_op = bus.binvert ? ~bus.src2 : bus.src2;

  alu_seq_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i       (a_op),
    .b_i       (b_op),
    .cin_i     (bus.binvert),
    .op_i      (bus.op),
    .result_c_o(core_res),
    .carry_c_o (core_carry),
    .ovf_c_o   (core_ovf)
  );

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  assign bus.in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
`else
  assign bus.in_ready = (state_q == ST_IDLE) || bus.out_ready;
`endif

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    carry_d  = carry_q;
`ifdef ALU_SEQ_MUL_EN
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`endif
    if (accept) begin
`ifdef ALU_SEQ_MUL_EN
      if (bus.op == OP_MUL) begin
        state_d  = ST_BUSY;
        mcand_d  = {{WIDTH{1'b0}}, bus.src1};
        mplier_d = bus.src2;
        acc_d    = '0;
        cnt_d    = '0;
      end else
`endif
      begin
        state_d  = ST_DONE;
        result_d = core_res;
        zero_d   = ~|core_res;
        ovf_d    = core_ovf;
        carry_d  = core_carry;
      end
    end else if ((state_q == ST_DONE) && bus.out_ready) begin
      state_d = ST_IDLE;
    end
`ifdef ALU_SEQ_MUL_EN
    else if (state_q == ST_BUSY) begin
      // WIDTH shift-add steps, then one cycle to publish the product.
      if (cnt_q == CntLast) begin
        state_d  = ST_DONE;
        result_d = acc_q[WIDTH-1:0];
        zero_d   = ~|acc_q[WIDTH-1:0];
        ovf_d    = |acc_q[2*WIDTH-1:WIDTH];
        carry_d  = 1'b0;
      end else begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      carry_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      carry_q  <= carry_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry     = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed plan steps plus random ops vs a model.
module tb_alu_seq;
  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         v;
    logic         c;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic z, input logic v, input logic c);
    exp_t e;
    e.res = r; e.z = z; e.v = v; e.c = c;
    return e;
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] s1,
                                 input logic [W-1:0] s2, input logic ai, input logic bi);
    exp_t e;
    logic [W-1:0] a, b;
    longint m, ua, ub, sa, sb, u, s, p;
    a  = ai ? ~s1 : s1;
    b  = bi ? ~s2 : s2;
    m  = longint'(1) << W;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - m : ua;
    sb = b[W-1] ? ub - m : ub;
    u  = ua + ub + longint'(bi);
    s  = sa + sb + longint'(bi);
    e  = '0;
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: begin
        e.res = W'(u);
        e.c   = (u >= m);
        e.v   = (s >= m / 2) || (s < -(m / 2));
      end
      3'd3: begin
        e.res[0] = (s < 0);
        e.c      = (u >= m);
      end
      3'd4: begin
`ifdef ALU_SEQ_MUL_EN
        p     = longint'(s1) * longint'(s2);
        e.res = W'(p);
        e.v   = (p >= m);
`else
        p = 0;
`endif
      end
      default: ;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic drive(input logic [2:0] op, input logic [W-1:0] s1, input logic [W-1:0] s2,
                       input logic ai, input logic bi);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.src1     = s1;
    bus.src2     = s2;
    bus.ainvert  = ai;
    bus.binvert  = bi;
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".valid"}, bus.out_valid, 1);
    chk({tag, ".result"}, bus.result, e.res);
    chk({tag, ".zero"}, bus.zero, e.z);
    chk({tag, ".overflow"}, bus.overflow, e.v);
    chk({tag, ".carry"}, bus.carry, e.c);
  endtask

  // Issue one single-cycle command and check the result one cycle later.
  task automatic single(input string tag, input logic [2:0] op, input logic [W-1:0] s1,
                        input logic [W-1:0] s2, input logic ai, input logic bi, input exp_t e);
    drive(op, s1, s2, ai, bi);
    bus.out_ready = 1'b1;
    #1;
    chk({tag, ".in_ready"}, bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_out(tag, e);
  endtask

  task automatic hold(input string tag, input int cycles, input exp_t e);
    bus.out_ready = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      #1;
      chk({tag, ".hold_rdy"}, bus.in_ready, 0);
      @(posedge clk);
      #1;
      check_out({tag, ".hold"}, e);
    end
    bus.out_ready = 1'b1;
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic mul(input string tag, input logic [W-1:0] s1, input logic [W-1:0] s2,
                     input exp_t e);
    int n;
    drive(3'd4, s1, s2, 1'($urandom), 1'($urandom));
    bus.out_ready = 1'b1;
    #1;
    chk({tag, ".in_ready"}, bus.in_ready, 1);
    @(posedge clk);
    #1;
    // A competing command during BUSY must not be taken.
    drive(3'd2, 8'h01, 8'h01, 1'b0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      chk({tag, ".busy_rdy"}, bus.in_ready, 0);
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    chk({tag, ".latency"}, n, W + 1);
    check_out(tag, e);
  endtask
`endif

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] r1, r2;
    logic         rai, rbi;
    exp_t         e;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(3'd0, '0, '0, 1'b0, 1'b0);
    bus.in_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", bus.out_valid, 0);
    chk("rst.result", bus.result, 0);
    chk("rst.zero", bus.zero, 1);
    chk("rst.overflow", bus.overflow, 0);
    chk("rst.carry", bus.carry, 0);
    rst = 1'b0;
    #1;
    chk("rst.in_ready", bus.in_ready, 1);

    single("add", 3'b010, 8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h80, 1'b0, 1'b1, 1'b0));
    single("sub", 3'b010, 8'h55, 8'h55, 1'b0, 1'b1, mk(8'h00, 1'b1, 1'b0, 1'b1));
    single("slt", 3'b011, 8'h80, 8'h01, 1'b0, 1'b1, mk(8'h01, 1'b0, 1'b0, 1'b1));
    single("slt_swap", 3'b011, 8'h01, 8'h80, 1'b0, 1'b1, mk(8'h00, 1'b1, 1'b0, 1'b0));
    single("or", 3'b001, 8'hA0, 8'h05, 1'b0, 1'b0, mk(8'hA5, 1'b0, 1'b0, 1'b0));
    single("rsv7", 3'b111, 8'hFF, 8'h12, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b0));
`ifndef ALU_SEQ_MUL_EN
    single("rsv4", 3'b100, 8'h10, 8'h20, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b0));
`endif

    single("nor", 3'b000, 8'hF0, 8'h0F, 1'b1, 1'b1, mk(8'h00, 1'b1, 1'b0, 1'b0));
    drive(3'b010, 8'h03, 8'h04, 1'b0, 1'b0);
    hold("nor", 3, mk(8'h00, 1'b1, 1'b0, 1'b0));
    #1;
    chk("bp.in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_out("bp.new", mk(8'h07, 1'b0, 1'b0, 1'b0));

`ifdef ALU_SEQ_MUL_EN
    mul("mul1", 8'h10, 8'h20, mk(8'h00, 1'b1, 1'b1, 1'b0));
    mul("mul2", 8'h0F, 8'h03, mk(8'h2D, 1'b0, 1'b0, 1'b0));
    drive(3'd4, 8'h0F, 8'h0F, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mulrst.busy", bus.out_valid, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mulrst.valid", bus.out_valid, 0);
    chk("mulrst.in_ready", bus.in_ready, 1);
    chk("mulrst.result", bus.result, 0);
    chk("mulrst.zero", bus.zero, 1);
`endif

    // Back-to-back ADDs: one result per cycle.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r1 = W'($urandom);
      r2 = W'($urandom);
      drive(3'b010, r1, r2, 1'b0, 1'b0);
      #1;
      chk("tput.in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      check_out("tput", model(3'b010, r1, r2, 1'b0, 1'b0));
    end
    bus.in_valid = 1'b0;

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(7, 0));
      r1  = W'($urandom);
      r2  = W'($urandom);
      rai = 1'($urandom);
      rbi = 1'($urandom);
      e   = model(rop, r1, r2, rai, rbi);
`ifdef ALU_SEQ_MUL_EN
      if (rop == 3'd4) mul("rnd_mul", r1, r2, e);
      else single("rnd", rop, r1, r2, rai, rbi, e);
`else
      single("rnd", rop, r1, r2, rai, rbi, e);
`endif
      if ($urandom_range(2, 0) == 0) hold("rnd", $urandom_range(2, 1), e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered ALU. Successor to the 8-bit ripple ALU.
- Keeps the Ainvert/Binvert/op control scheme (AND, OR, ADD/SUB, SLT, NOR).
- Adds a WIDTH parameter, valid/ready handshakes, registered flags (zero, overflow, carry) and an optional multi-cycle shift-add multiply.
- Sits between the operand/decode stage and the writeback stage of the course datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 4 to 32).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/command valid
- in_ready  out  1  block can accept a command this cycle
- src1  in  WIDTH  operand A
- src2  in  WIDTH  operand B
- ainvert  in  1  invert A before the bit-slice op
- binvert  in  1  invert B; also the carry-in (subtract)
- op  in  3  000 AND, 001 OR, 010 ADD, 011 SLT, 100 MUL, 101-111 reserved
- out_valid  out  1  result/flags valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- overflow  out  1  see Behaviour
- carry  out  1  carry out of MSB (ADD/SUB/SLT), else 0

Behaviour:
- Clock and reset: single clock domain; rst is sampled on the rising clk edge. Reset is synchronous and active-high and overrides all other activity, including an in-flight MUL.
- Reset values: state=IDLE, out_valid=0, result=0, zero=1, overflow=0, carry=0. in_ready=1 in the first cycle after reset.
- States: IDLE, BUSY (MUL only), DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is 0 in BUSY.
- Accept occurs when in_valid && in_ready.
- Single-cycle ops (AND, OR, ADD, SLT, reserved): result registered on the accept edge. out_valid=1 the next cycle (latency 1). State goes to DONE.
- Back-to-back ops: in DONE with out_ready && in_valid, a new single-cycle op replaces the output in the same edge. State stays DONE, so throughput is 1 op per cycle.
- Operand formation: a' = ainvert ? ~src1 : src1; b' = binvert ? ~src2 : src2; cin = binvert.
- AND: a'&b'. With ainvert=binvert=1 this gives NOR.
- OR: a'|b'.
- ADD: sum = a'+b'+cin, WIDTH-bit wrap. carry = bit WIDTH of the sum. overflow = signed overflow (a'[MSB]==b'[MSB] && sum[MSB]!=a'[MSB]).
- SLT: sum computed as for ADD. result = {0..0, sum[MSB]^ovf}. carry as for ADD. overflow=0.
- Logic ops and reserved ops: carry=0, overflow=0. Reserved ops give result=0, zero=1.
- MUL: unsigned src1*src2; ainvert and binvert are ignored. On accept, load multiplicand, multiplier and a 2*WIDTH accumulator, and go to BUSY.
- MUL timing: one shift-add step per cycle for WIDTH cycles, using a counter of clog2(WIDTH)+1 bits. Then go to DONE. out_valid rises WIDTH+1 cycles after accept.
- MUL outputs: result = low WIDTH bits. overflow = |high WIDTH bits. carry=0.
- zero = ~|result, registered together with result.
- Output holding: out_valid && !out_ready holds result and flags stable and keeps in_ready=0.
- DONE with out_ready && !in_valid: go to IDLE and set out_valid=0.
- in_valid seen during BUSY is ignored; no accept occurs.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: MUL, the BUSY state and the shift-add counter/accumulator are present as described above.
- Undefined: op=100 is treated as reserved (single-cycle, result=0, zero=1, flags 0). No BUSY state and no multiplier registers are synthesised. in_ready = (state==IDLE) || out_ready.

Decomposition:
- Package alu_seq_pkg holds:
  - op encoding localparams: OP_AND, OP_OR, OP_ADD, OP_SLT, OP_MUL
  - state encoding: ST_IDLE, ST_BUSY, ST_DONE
- Sub-module alu_seq_core: combinational, WIDTH-parametrised datapath. It takes a', b', cin and op, and produces result_c, carry_c and ovf_c.
- Top level alu_seq holds the FSM, the handshake logic, the output registers and the MUL sequencer.

Test Plan (WIDTH=8):
- ADD: src1=0x7F, src2=0x01, ainvert=0, binvert=0, op=010 -> one cycle later result=0x80, overflow=1, carry=0, zero=0.
- SUB/zero: src1=0x55, src2=0x55, binvert=1, op=010 -> result=0x00, zero=1, carry=1, overflow=0.
- SLT: src1=0x80 (-128), src2=0x01, binvert=1, op=011 -> result=0x01. Swapping the operands -> result=0x00.
- NOR and backpressure: src1=0xF0, src2=0x0F, ainvert=1, binvert=1, op=000 -> result=0x00. Hold out_ready=0 for 3 cycles -> result stable and in_ready=0. Set out_ready=1 with a new command -> accepted on that edge.
- MUL (ALU_SEQ_MUL_EN defined): 0x10*0x20 -> out_valid after 9 cycles, result=0x00, overflow=1, zero=1. Repeat 0x0F*0x03 -> result=0x2D, overflow=0. Pulse rst at BUSY cycle 4 -> next cycle IDLE, out_valid=0, in_ready=1.
- Throughput: 4 back-to-back ADDs with out_ready=1 -> 4 results on 4 consecutive cycles, with no bubble.
